lcd_rgb_rx: RTL and testbench

LCD_RGB_RX -- requirements
Module: lcd_rgb_rx

---
 rtl/lcd_rgb_rx.sv | 273 +++++++++++++++++++++++++++
 tb/tb_lcd_rgb_rx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_rx.sv
// RGB565 parallel LCD receiver: captures DE-qualified pixels with coordinates and
// measures line/frame geometry against the expected active resolution.
module lcd_rgb_rx #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned V_ACTIVE = 272
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        LCD_DE,
    input  logic        LCD_HSYNC,
    input  logic        LCD_VSYNC,
    input  logic [4:0]  LCD_R,
    input  logic [5:0]  LCD_G,
    input  logic [4:0]  LCD_B,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        sof,
    output logic        eol,
    output logic        line_err,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] meas_width,
    output logic [15:0] meas_height,
    output logic [15:0] meas_htotal,
    output logic [7:0]  err_count
);

    localparam int unsigned CW = 16;
    localparam int unsigned XW = 9;
    localparam int unsigned EW = 8;
    localparam int unsigned PW = 16;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [XW-1:0] XY_MAX  = {XW{1'b1}};
    localparam logic [CW-1:0] H_EXP   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_EXP   = CW'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_SEEK  = 2'd0,
        ST_BLANK = 2'd1,
        ST_LINE  = 2'd2
    } state_e;

    function automatic logic [CW-1:0] inc_cnt(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    function automatic logic [XW-1:0] inc_xy(input logic [XW-1:0] v);
        return (v == XY_MAX) ? v : v + XW'(1);
    endfunction

    // input capture (S1) and its delayed copy (S2) for edge detection
    logic          de_s1_q, de_s1_d;
    logic          hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
    logic          vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
    logic [PW-1:0] rgb_s1_q, rgb_s1_d;

    always_comb begin
        de_s1_d  = LCD_DE;
        hs_s1_d  = LCD_HSYNC;
        vs_s1_d  = LCD_VSYNC;
        rgb_s1_d = {LCD_R, LCD_G, LCD_B};
        hs_s2_d  = hs_s1_q;
        vs_s2_d  = vs_s1_q;
    end

    logic vs_rise_c;
    logic hs_rise_c;
    assign vs_rise_c = vs_s1_q & ~vs_s2_q;
    assign hs_rise_c = hs_s1_q & ~hs_s2_q;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [XW-1:0] y_q, y_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] lines_q, lines_d;
    logic          ferr_q, ferr_d;
    logic [CW-1:0] htcnt_q, htcnt_d;

    logic          pix_valid_q, pix_valid_d;
    logic [PW-1:0] pix_data_q, pix_data_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic [XW-1:0] pix_y_q, pix_y_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic          line_err_q, line_err_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_ok_q, frame_ok_d;
    logic [CW-1:0] meas_width_q, meas_width_d;
    logic [CW-1:0] meas_height_q, meas_height_d;
    logic [CW-1:0] meas_htotal_q, meas_htotal_d;
    logic [EW-1:0] err_count_q, err_count_d;

    logic          emit_c;
    logic          line_close_c;
    logic          frame_close_c;
    logic          in_frame_c;
    logic          line_bad_c;
    logic [XW-1:0] x_pix_c;
    logic [CW-1:0] lines_nxt_c;
    logic          ferr_nxt_c;

    // FSM next-state and pixel / line / frame bookkeeping
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        len_d         = len_q;
        lines_d       = lines_q;
        ferr_d        = ferr_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        sof_d         = 1'b0;
        eol_d         = 1'b0;
        line_err_d    = 1'b0;
        frame_done_d  = 1'b0;
        frame_ok_d    = frame_ok_q;
        meas_width_d  = meas_width_q;
        meas_height_d = meas_height_q;
        x_pix_c       = '0;
        line_bad_c    = 1'b0;
        lines_nxt_c   = lines_q;
        ferr_nxt_c    = ferr_q;

        in_frame_c    = (state_q == ST_BLANK) || (state_q == ST_LINE);
        emit_c        = in_frame_c && de_s1_q && !vs_rise_c;
        line_close_c  = (state_q == ST_LINE) && (!de_s1_q || vs_rise_c);
        frame_close_c = in_frame_c && vs_rise_c;

        if (emit_c) begin
            x_pix_c     = (state_q == ST_LINE) ? x_q : '0;
            pix_valid_d = 1'b1;
            pix_data_d  = rgb_s1_q;
            pix_x_d     = x_pix_c;
            pix_y_d     = y_q;
            sof_d       = (x_pix_c == '0) && (y_q == '0);
            eol_d       = !LCD_DE;
            x_d         = inc_xy(x_pix_c);
            len_d       = (state_q == ST_LINE) ? inc_cnt(len_q) : CW'(1);
            state_d     = ST_LINE;
        end

        // DE still high here means VSYNC cut the line short
        if (line_close_c) begin
            line_bad_c   = de_s1_q || (len_q != H_EXP);
            line_err_d   = line_bad_c;
            meas_width_d = len_q;
            lines_nxt_c  = inc_cnt(lines_q);
            ferr_nxt_c   = ferr_q | line_bad_c;
            y_d          = inc_xy(y_q);
            lines_d      = lines_nxt_c;
            ferr_d       = ferr_nxt_c;
            state_d      = ST_BLANK;
        end

        if (frame_close_c) begin
            frame_done_d  = 1'b1;
            frame_ok_d    = (lines_nxt_c == V_EXP) && !ferr_nxt_c;
            meas_height_d = lines_nxt_c;
            y_d           = '0;
            lines_d       = '0;
            ferr_d        = 1'b0;
            state_d       = ST_BLANK;
        end

        if (state_q == ST_SEEK && vs_rise_c) begin
            y_d     = '0;
            lines_d = '0;
            ferr_d  = 1'b0;
            state_d = ST_BLANK;
        end

        if (!in_frame_c && state_q != ST_SEEK) begin
            state_d = ST_SEEK;
        end
    end

    logic [1:0]    err_inc_c;
    logic [EW:0]   err_sum_c;

    // saturating error counter, line and frame errors may land together
    always_comb begin
        err_inc_c   = {1'b0, line_err_d} + {1'b0, frame_done_d & ~frame_ok_d};
        err_sum_c   = {1'b0, err_count_q} + (EW+1)'(err_inc_c);
        err_count_d = err_sum_c[EW] ? {EW{1'b1}} : err_sum_c[EW-1:0];
    end

    // HSYNC period measurement, independent of the frame FSM
    always_comb begin
        htcnt_d       = inc_cnt(htcnt_q);
        meas_htotal_d = meas_htotal_q;
        if (hs_rise_c) begin
            meas_htotal_d = htcnt_q;
            htcnt_d       = CW'(1);
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_s1_q       <= 1'b0;
            hs_s1_q       <= 1'b0;
            hs_s2_q       <= 1'b0;
            vs_s1_q       <= 1'b0;
            vs_s2_q       <= 1'b0;
            rgb_s1_q      <= '0;
            state_q       <= ST_SEEK;
            x_q           <= '0;
            y_q           <= '0;
            len_q         <= '0;
            lines_q       <= '0;
            ferr_q        <= 1'b0;
            htcnt_q       <= '0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            line_err_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            meas_width_q  <= '0;
            meas_height_q <= '0;
            meas_htotal_q <= '0;
            err_count_q   <= '0;
        end else begin
            de_s1_q       <= de_s1_d;
            hs_s1_q       <= hs_s1_d;
            hs_s2_q       <= hs_s2_d;
            vs_s1_q       <= vs_s1_d;
            vs_s2_q       <= vs_s2_d;
            rgb_s1_q      <= rgb_s1_d;
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            len_q         <= len_d;
            lines_q       <= lines_d;
            ferr_q        <= ferr_d;
            htcnt_q       <= htcnt_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            sof_q         <= sof_d;
            eol_q         <= eol_d;
            line_err_q    <= line_err_d;
            frame_done_q  <= frame_done_d;
            frame_ok_q    <= frame_ok_d;
            meas_width_q  <= meas_width_d;
            meas_height_q <= meas_height_d;
            meas_htotal_q <= meas_htotal_d;
            err_count_q   <= err_count_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign sof         = sof_q;
    assign eol         = eol_q;
    assign line_err    = line_err_q;
    assign frame_done  = frame_done_q;
    assign frame_ok    = frame_ok_q;
    assign meas_width  = meas_width_q;
    assign meas_height = meas_height_q;
    assign meas_htotal = meas_htotal_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Directed bench for lcd_rgb_rx using a reduced 16x8 active geometry.
module tb_lcd_rgb_rx;

    localparam int unsigned H = 16;
    localparam int unsigned V = 8;

    logic        PixelClk;
    logic        nRST;
    logic        LCD_DE, LCD_HSYNC, LCD_VSYNC;
    logic [4:0]  LCD_R;
    logic [5:0]  LCD_G;
    logic [4:0]  LCD_B;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [8:0]  pix_x, pix_y;
    logic        sof, eol, line_err, frame_done, frame_ok;
    logic [15:0] meas_width, meas_height, meas_htotal;
    logic [7:0]  err_count;
    logic [95:0] all_out;

    lcd_rgb_rx #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .PixelClk   (PixelClk),
        .nRST       (nRST),
        .LCD_DE     (LCD_DE),
        .LCD_HSYNC  (LCD_HSYNC),
        .LCD_VSYNC  (LCD_VSYNC),
        .LCD_R      (LCD_R),
        .LCD_G      (LCD_G),
        .LCD_B      (LCD_B),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .sof        (sof),
        .eol        (eol),
        .line_err   (line_err),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .meas_width (meas_width),
        .meas_height(meas_height),
        .meas_htotal(meas_htotal),
        .err_count  (err_count)
    );

    assign all_out = {pix_valid, pix_data, pix_x, pix_y, sof, eol, line_err, frame_done,
                      frame_ok, meas_width, meas_height, meas_htotal, err_count};

    initial PixelClk = 1'b0;
    always #5 PixelClk = ~PixelClk;

    int n_vec = 0;
    int n_mis = 0;

    // event counters sampled mid-cycle; the sequence compares deltas
    int n_pix = 0, n_eol = 0, n_sof = 0, n_lerr = 0, n_fd = 0, n_both = 0;
    int n_xnz = 0, n_x511 = 0, n_dbad = 0;
    logic last_fok = 1'b0;
    logic [15:0] exp_d;

    always @(negedge PixelClk) begin
        if (pix_valid) begin
            n_pix++;
            if (eol) n_eol++;
            if (sof) n_sof++;
            if (pix_x != 9'd0) n_xnz++;
            if (pix_x == 9'd511) n_x511++;
            else begin
                exp_d = {5'(pix_x), 6'(pix_y), ~(5'(pix_x))};
                if (pix_data !== exp_d) n_dbad++;
            end
        end
        if (line_err) n_lerr++;
        if (frame_done) begin
            n_fd++;
            last_fok = frame_ok;
        end
        if (line_err && frame_done) n_both++;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic de, input logic hs, input logic vs, input int x, input int y);
        LCD_DE    = de;
        LCD_HSYNC = hs;
        LCD_VSYNC = vs;
        LCD_R     = 5'(x);
        LCD_G     = 6'(y);
        LCD_B     = ~(5'(x));
        @(posedge PixelClk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic vs_pulse();
        drv(1'b0, 1'b0, 1'b1, 0, 0);
        drv(1'b0, 1'b0, 1'b1, 0, 0);
        idle(3);
    endtask

    // 2 HSYNC + 2 back porch + len DE + 3 front porch = len+7 clocks
    task automatic gen_line(input int len, input int y);
        drv(1'b0, 1'b1, 1'b0, 0, 0);
        drv(1'b0, 1'b1, 1'b0, 0, 0);
        idle(2);
        for (int i = 0; i < len; i++) drv(1'b1, 1'b0, 1'b0, i, y);
        idle(3);
    endtask

    task automatic gen_frame(input int short_idx, input int short_len);
        for (int l = 0; l < int'(V); l++) gen_line((l == short_idx) ? short_len : int'(H), l);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle(2);
        nRST = 1'b1;
        idle(2);
    endtask

    int b_pix, b_eol, b_sof, b_lerr, b_fd, b_both, b_xnz, b_x511;

    task automatic snap();
        b_pix = n_pix; b_eol = n_eol; b_sof = n_sof; b_lerr = n_lerr;
        b_fd = n_fd; b_both = n_both; b_xnz = n_xnz; b_x511 = n_x511;
    endtask

    initial begin
        nRST = 1'b1;
        LCD_DE = 1'b0; LCD_HSYNC = 1'b0; LCD_VSYNC = 1'b0;
        LCD_R = '0; LCD_G = '0; LCD_B = '0;
        #2 nRST = 1'b0;
        #1;
        chk("reset_outputs_zero", all_out, 96'd0);
        idle(2);
        nRST = 1'b1;
        idle(2);

        // two nominal frames, closed by a third VSYNC
        snap();
        vs_pulse();
        gen_frame(-1, 0);
        vs_pulse();
        gen_frame(-1, 0);
        vs_pulse();
        chk("nom_frame_done_cnt", 96'(n_fd - b_fd), 96'd2);
        chk("nom_frame_ok", 96'(last_fok), 96'd1);
        chk("nom_frame_ok_out", 96'(frame_ok), 96'd1);
        chk("nom_meas_width", 96'(meas_width), 96'd16);
        chk("nom_meas_height", 96'(meas_height), 96'd8);
        chk("nom_err_count", 96'(err_count), 96'd0);
        chk("nom_pixels", 96'(n_pix - b_pix), 96'd256);
        chk("nom_eol_cnt", 96'(n_eol - b_eol), 96'd16);
        chk("nom_sof_cnt", 96'(n_sof - b_sof), 96'd2);
        chk("nom_line_err_cnt", 96'(n_lerr - b_lerr), 96'd0);
        chk("nom_htotal", 96'(meas_htotal), 96'd23);

        // single-clock DE pulse: one-cycle-later strobe, sof and eol together
        do_reset();
        vs_pulse();
        idle(95);
        drv(1'b1, 1'b0, 1'b0, 0, 0);
        chk("lat_valid_early", 96'(pix_valid), 96'd0);
        drv(1'b0, 1'b0, 1'b0, 0, 0);
        chk("lat_valid", 96'(pix_valid), 96'd1);
        chk("lat_x", 96'(pix_x), 96'd0);
        chk("lat_y", 96'(pix_y), 96'd0);
        chk("lat_sof", 96'(sof), 96'd1);
        chk("lat_eol", 96'(eol), 96'd1);
        chk("lat_data", 96'(pix_data), 96'h001f);
        chk("lat_line_err_early", 96'(line_err), 96'd0);
        drv(1'b0, 1'b0, 1'b0, 0, 0);
        chk("lat_valid_after", 96'(pix_valid), 96'd0);
        chk("lat_line_err", 96'(line_err), 96'd1);
        chk("lat_meas_width", 96'(meas_width), 96'd1);
        vs_pulse();
        chk("lat_frame_ok", 96'(frame_ok), 96'd0);
        chk("lat_meas_height", 96'(meas_height), 96'd1);
        chk("lat_err_count", 96'(err_count), 96'd2);

        // one short line in an otherwise nominal frame
        do_reset();
        snap();
        vs_pulse();
        gen_frame(5, 15);
        vs_pulse();
        chk("short_line_err_cnt", 96'(n_lerr - b_lerr), 96'd1);
        chk("short_frame_done_cnt", 96'(n_fd - b_fd), 96'd1);
        chk("short_frame_ok", 96'(last_fok), 96'd0);
        chk("short_meas_height", 96'(meas_height), 96'd8);
        chk("short_err_count", 96'(err_count), 96'd2);

        // VSYNC rises while the last line still has DE high
        do_reset();
        snap();
        vs_pulse();
        for (int l = 0; l < int'(V) - 1; l++) gen_line(int'(H), l);
        drv(1'b0, 1'b1, 1'b0, 0, 0);
        drv(1'b0, 1'b1, 1'b0, 0, 0);
        idle(2);
        for (int i = 0; i < 8; i++) drv(1'b1, 1'b0, 1'b0, i, 7);
        drv(1'b1, 1'b0, 1'b1, 8, 7);
        drv(1'b0, 1'b0, 1'b1, 0, 0);
        idle(3);
        chk("trunc_same_cycle", 96'(n_both - b_both), 96'd1);
        chk("trunc_line_err_cnt", 96'(n_lerr - b_lerr), 96'd1);
        chk("trunc_frame_done_cnt", 96'(n_fd - b_fd), 96'd1);
        chk("trunc_frame_ok", 96'(last_fok), 96'd0);
        chk("trunc_meas_width", 96'(meas_width), 96'd8);
        chk("trunc_meas_height", 96'(meas_height), 96'd8);
        chk("trunc_err_count", 96'(err_count), 96'd2);

        // asynchronous reset in the middle of line 4
        do_reset();
        vs_pulse();
        for (int l = 0; l < 4; l++) gen_line(int'(H), l);
        drv(1'b0, 1'b1, 1'b0, 0, 0);
        drv(1'b0, 1'b1, 1'b0, 0, 0);
        idle(2);
        for (int i = 0; i < 6; i++) drv(1'b1, 1'b0, 1'b0, i, 4);
        chk("rst_pre_valid", 96'(pix_valid), 96'd1);
        nRST = 1'b0;
        #1;
        chk("rst_async_zero", all_out, 96'd0);
        snap();
        drv(1'b1, 1'b0, 1'b0, 6, 4);
        drv(1'b1, 1'b0, 1'b0, 7, 4);
        nRST = 1'b1;
        for (int i = 8; i < int'(H); i++) drv(1'b1, 1'b0, 1'b0, i, 4);
        idle(3);
        for (int l = 5; l < int'(V); l++) gen_line(int'(H), l);
        chk("rst_no_pixels", 96'(n_pix - b_pix), 96'd0);
        vs_pulse();
        gen_frame(-1, 0);
        vs_pulse();
        chk("rst_frame_done_cnt", 96'(n_fd - b_fd), 96'd1);
        chk("rst_frame_ok", 96'(last_fok), 96'd1);
        chk("rst_err_count", 96'(err_count), 96'd0);

        // over-long line: x coordinate saturates at 511, length does not
        do_reset();
        snap();
        vs_pulse();
        gen_line(520, 0);
        chk("xsat_count_511", 96'(n_x511 - b_x511), 96'd9);
        chk("xsat_pixels", 96'(n_pix - b_pix), 96'd520);
        chk("xsat_meas_width", 96'(meas_width), 96'd520);

        // 300 tiny frames, each with a one-clock line
        do_reset();
        snap();
        for (int f = 0; f < 300; f++) begin
            drv(1'b0, 1'b0, 1'b1, 0, 0);
            drv(1'b0, 1'b0, 1'b0, 0, 0);
            drv(1'b1, 1'b0, 1'b0, 0, 0);
            drv(1'b0, 1'b0, 1'b0, 0, 0);
            drv(1'b0, 1'b0, 1'b0, 0, 0);
        end
        chk("esat_err_count", 96'(err_count), 96'd255);
        chk("esat_pixels", 96'(n_pix - b_pix), 96'd300);
        chk("esat_x_nonzero", 96'(n_xnz - b_xnz), 96'd0);
        chk("esat_pix_x", 96'(pix_x), 96'd0);

        chk("pix_data_map", 96'(n_dbad), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
